// File: rtl/cache_requester.sv
// Clocked initiator for the dual-rail, four-phase cache port: turns a valid/ready
// CPU request into dual-rail codewords, runs the handshake and returns a response.
module cache_requester #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  cache_addr,
  output logic [15:0] cache_wdata,
  output logic [1:0]  cache_rnw,
  output logic        cache_ack_in_read,
  input  logic [15:0] cache_rdata,
  input  logic        cache_ack_read,
  input  logic        cache_ack_write
);

  typedef enum logic [2:0] {IDLE, W_ACK, W_RTZ, R_ACK, R_RTZ} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t                 state;
  logic                   op_write;
  logic [CW-1:0]          tmo_cnt;
  logic [7:0]             rd_data;
  logic                   rd_err;
  logic [SYNC_STAGES-1:0] ack_rd_sync;
  logic [SYNC_STAGES-1:0] ack_wr_sync;
  logic                   ack_rd_s;
  logic                   ack_wr_s;
  logic                   advance;
  logic                   tmo_hit;
  logic [7:0]             rd_value;
  logic                   rd_bad;
  logic [15:0]            addr_code;

  // Logical bit i maps to rails {[2i+1], [2i]} = {bit, ~bit}; all-zero is the spacer.
  function automatic logic [15:0] dr_encode(input logic [7:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  assign addr_code = dr_encode({6'b0, req_addr});

  // Acks are asynchronous to clk; only the last synchronizer stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_rd_sync <= '0;
      ack_wr_sync <= '0;
    end else begin
      ack_rd_sync <= {ack_rd_sync[SYNC_STAGES-2:0], cache_ack_read};
      ack_wr_sync <= {ack_wr_sync[SYNC_STAGES-2:0], cache_ack_write};
    end
  end

  assign ack_rd_s = ack_rd_sync[SYNC_STAGES-1];
  assign ack_wr_s = ack_wr_sync[SYNC_STAGES-1];

  always_comb begin
    rd_value = '0;
    rd_bad   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_value[i] = cache_rdata[2*i+1];
      if (cache_rdata[2*i+1] == cache_rdata[2*i]) rd_bad = 1'b1;
    end
  end

  always_comb begin
    advance = 1'b0;
    case (state)
      W_ACK:   advance = ack_wr_s;
      W_RTZ:   advance = !ack_wr_s;
      R_ACK:   advance = ack_rd_s;
      R_RTZ:   advance = !ack_rd_s;
      default: advance = 1'b0;
    endcase
  end

  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == CW'(TIMEOUT));

  // NOTE: every output is a flop so the cache never sees combinational glitches on
  // its rails; state and outputs update with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      req_ready         <= 1'b1;
      rsp_valid         <= 1'b0;
      rsp_write         <= 1'b0;
      rsp_rdata         <= '0;
      rsp_err           <= 1'b0;
      cache_addr        <= '0;
      cache_wdata       <= '0;
      cache_rnw         <= 2'b00;
      cache_ack_in_read <= 1'b0;
      tmo_cnt           <= '0;
      op_write          <= 1'b0;
      rd_data           <= '0;
      rd_err            <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state != IDLE && !advance && tmo_hit) begin
        // Abort: return every rail to spacer and report an error completion.
        cache_addr        <= '0;
        cache_wdata       <= '0;
        cache_rnw         <= 2'b00;
        cache_ack_in_read <= 1'b0;
        rsp_valid         <= 1'b1;
        rsp_write         <= op_write;
        rsp_err           <= 1'b1;
        rsp_rdata         <= '0;
        tmo_cnt           <= '0;
        state             <= IDLE;
      end else begin
        if (state != IDLE && !advance && TIMEOUT != 0) tmo_cnt <= tmo_cnt + 1'b1;
        else                                           tmo_cnt <= '0;
        case (state)
          IDLE: begin
            req_ready <= 1'b1;
            if (req_valid && req_ready) begin
              op_write    <= req_write;
              cache_addr  <= addr_code[3:0];
              cache_wdata <= req_write ? dr_encode(req_wdata) : 16'h0000;
              cache_rnw   <= req_write ? 2'b01 : 2'b10;
              req_ready   <= 1'b0;
              state       <= req_write ? W_ACK : R_ACK;
            end
          end
          W_ACK: if (advance) begin
            cache_addr  <= '0;
            cache_wdata <= '0;
            cache_rnw   <= 2'b00;
            state       <= W_RTZ;
          end
          W_RTZ: if (advance) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
          R_ACK: if (advance) begin
            rd_data           <= rd_value;
            rd_err            <= rd_bad;
            cache_ack_in_read <= 1'b1;
            cache_addr        <= '0;
            cache_rnw         <= 2'b00;
            state             <= R_RTZ;
          end
          R_RTZ: if (advance) begin
            cache_ack_in_read <= 1'b0;
            rsp_valid         <= 1'b1;
            rsp_write         <= 1'b0;
            rsp_rdata         <= rd_data;
            rsp_err           <= rd_err;
            state             <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
